// File: rtl/audio_pkg.sv
// Shared constants for the audio output path: sample width, clock-divider
// tap positions and the derived frame geometry.
package audio_pkg;

    localparam int AUDIO_DW     = 16;

    // Counter bit positions that drive the DAC clocks (clk/4, clk/32, clk/1024)
    localparam int MCLK_SHIFT   = 1;
    localparam int SCK_SHIFT    = 4;
    localparam int LRCK_SHIFT   = 9;

    localparam int FRAME_CLKS   = 1 << (LRCK_SHIFT + 1);
    localparam int SLOTS_PER_CH = 1 << (LRCK_SHIFT - SCK_SHIFT - 1);

    localparam logic [AUDIO_DW-1:0] AUDIO_SILENCE = 16'h0000;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter for the I2S transmitter. MCLK, SCK and LRCK are
// taken straight from counter flops, so they are glitch-free by construction.
// slot_start is high on the clk whose rising edge enters the next slot
// (coincides with the SCK falling edge); frame_end marks the last clk of a frame.
module i2s_clk_gen #(
    parameter int MCLK_SHIFT = audio_pkg::MCLK_SHIFT,
    parameter int SCK_SHIFT  = audio_pkg::SCK_SHIFT,
    parameter int LRCK_SHIFT = audio_pkg::LRCK_SHIFT
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              mclk,
    output logic                              sck,
    output logic                              lrck,
    output logic [LRCK_SHIFT-SCK_SHIFT-1:0]   slot,
    output logic                              slot_start,
    output logic                              frame_end
);

    localparam logic [LRCK_SHIFT:0] CNT_ONE = 1;

    logic [LRCK_SHIFT:0] cnt;

    // Frame counter: wraps from all-ones back to zero, one frame per wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign mclk       = cnt[MCLK_SHIFT];
    assign sck        = cnt[SCK_SHIFT];
    assign lrck       = cnt[LRCK_SHIFT];
    assign slot       = cnt[LRCK_SHIFT:SCK_SHIFT+1];
    assign slot_start = &cnt[SCK_SHIFT:0];
    assign frame_end  = &cnt;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the Pmod DAC. Latches one stereo pair per frame through
// a valid/ack handshake on the last clk of the frame, substitutes silence and
// counts an underrun when no pair is offered, and shifts SDIN out MSB first
// with the standard one-SCK delay after each LRCK edge.
module audio_i2s_tx #(
    parameter int DW         = audio_pkg::AUDIO_DW,
    parameter int MCLK_SHIFT = audio_pkg::MCLK_SHIFT,
    parameter int SCK_SHIFT  = audio_pkg::SCK_SHIFT,
    parameter int LRCK_SHIFT = audio_pkg::LRCK_SHIFT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] audio_left,
    input  logic [DW-1:0] audio_right,
    input  logic          sample_valid,
    output logic          sample_ack,
    output logic [7:0]    underrun_cnt,
    output logic          audio_mclk,
    output logic          audio_lrck,
    output logic          audio_sck,
    output logic          audio_sdin
);

    import audio_pkg::*;

    // Slots per channel; must be at least DW for a full word to fit
    localparam int H  = 1 << (LRCK_SHIFT - SCK_SHIFT - 1);
    localparam int SW = LRCK_SHIFT - SCK_SHIFT;
    localparam int IW = $clog2(DW);
    localparam logic [SW-1:0] SLOT_ONE = 1;

    logic [SW-1:0] slot;
    logic [SW-1:0] slot_next;
    logic          slot_start;
    logic          frame_end;
    logic [DW-1:0] hold_l;
    logic [DW-1:0] hold_r;
    logic [7:0]    underrun_q;
    logic          sdin_q;
    logic          sdin_nxt;
    int            slot_i;

    i2s_clk_gen #(
        .MCLK_SHIFT (MCLK_SHIFT),
        .SCK_SHIFT  (SCK_SHIFT),
        .LRCK_SHIFT (LRCK_SHIFT)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .mclk       (audio_mclk),
        .sck        (audio_sck),
        .lrck       (audio_lrck),
        .slot       (slot),
        .slot_start (slot_start),
        .frame_end  (frame_end)
    );

    assign slot_next = slot + SLOT_ONE;

    // Bit to present in the slot about to start. Entering slot 0 happens on the
    // same edge that reloads hold_r, so hold_r[0] here is still the previous
    // frame's right LSB, which is the bit carried into the new frame.
    always_comb begin
        slot_i   = int'(slot_next);
        sdin_nxt = 1'b0;
        if (slot_i == 0) begin
            sdin_nxt = (H == DW) ? hold_r[0] : 1'b0;
        end else if (slot_i <= DW) begin
            sdin_nxt = hold_l[IW'(DW - slot_i)];
        end else if (slot_i >= H + 1 && slot_i <= H + DW && slot_i < 2 * H) begin
            sdin_nxt = hold_r[IW'(H + DW - slot_i)];
        end
    end

    // Serial data register, advanced on the clk edge that enters each slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdin_q <= 1'b0;
        end else if (slot_start) begin
            sdin_q <= sdin_nxt;
        end
    end

    // Sample latch and underrun accounting at the last clk of the frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_l     <= '0;
            hold_r     <= '0;
            underrun_q <= '0;
        end else if (frame_end) begin
            if (sample_valid) begin
                hold_l <= audio_left;
                hold_r <= audio_right;
            end else begin
                hold_l <= DW'(AUDIO_SILENCE);
                hold_r <= DW'(AUDIO_SILENCE);
                if (underrun_q != 8'hFF) begin
                    underrun_q <= underrun_q + 8'd1;
                end
            end
        end
    end

    assign sample_ack   = frame_end & sample_valid;
    assign underrun_cnt = underrun_q;
    assign audio_sdin   = sdin_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: frame-level reference model (queue of latched pairs,
// clocks from clk count arithmetic, serial words decoded at SCK rising edges).
module tb_audio_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] audio_left = '0;
    logic [15:0] audio_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ack;
    logic [7:0]  underrun_cnt;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

    // second, short-frame instance used for underrun saturation
    logic        rst_s = 1'b0;
    logic        s_ack;
    logic [7:0]  s_und;
    logic        s_mclk, s_lrck, s_sck, s_sdin;

    always #5 clk = ~clk;

    audio_i2s_tx dut (
        .clk          (clk),
        .rst          (rst),
        .audio_left   (audio_left),
        .audio_right  (audio_right),
        .sample_valid (sample_valid),
        .sample_ack   (sample_ack),
        .underrun_cnt (underrun_cnt),
        .audio_mclk   (audio_mclk),
        .audio_lrck   (audio_lrck),
        .audio_sck    (audio_sck),
        .audio_sdin   (audio_sdin)
    );

    audio_i2s_tx #(
        .DW         (16),
        .MCLK_SHIFT (0),
        .SCK_SHIFT  (0),
        .LRCK_SHIFT (5)
    ) dut_s (
        .clk          (clk),
        .rst          (rst_s),
        .audio_left   (16'h0000),
        .audio_right  (16'h0000),
        .sample_valid (1'b0),
        .sample_ack   (s_ack),
        .underrun_cnt (s_und),
        .audio_mclk   (s_mclk),
        .audio_lrck   (s_lrck),
        .audio_sck    (s_sck),
        .audio_sdin   (s_sdin)
    );

    int          total = 0;
    int          bad = 0;
    int          t;
    int          und = 0;
    int          ack_seen = 0;
    int          mc, mf, ms;
    logic [15:0] lat_l[$];
    logic [15:0] lat_r[$];
    logic [15:0] lacc = '0;
    logic [14:0] racc = '0;
    logic [15:0] expw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
        end
    endtask

    // clks since reset release == expected frame counter value (mod frame)
    always @(posedge clk or negedge rst) begin
        if (!rst) t <= 0;
        else      t <= t + 1;
    end

    // per-clk reference checks plus word decode at SCK rising edges
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mc = t % 1024;
            mf = t / 1024;
            chk("mclk", 32'(audio_mclk), 32'((mc >> 1) & 1));
            chk("sck", 32'(audio_sck), 32'((mc >> 4) & 1));
            chk("lrck", 32'(audio_lrck), 32'((mc >> 9) & 1));
            chk("ack", 32'(sample_ack), 32'(mc == 1023 && sample_valid));
            chk("underrun", 32'(underrun_cnt), 32'(und));
            if (sample_ack === 1'b1) ack_seen++;
            if (mc == 1023) begin
                lat_l.push_back(sample_valid ? audio_left : 16'h0000);
                lat_r.push_back(sample_valid ? audio_right : 16'h0000);
                if (!sample_valid && und < 255) und++;
            end
            if (mc % 32 == 16) begin
                ms = mc / 32;
                if (ms >= 1 && ms <= 16) begin
                    lacc = {lacc[14:0], audio_sdin};
                    if (ms == 16) begin
                        expw = (mf >= 1) ? lat_l[mf-1] : 16'h0000;
                        chk("left_word", 32'(lacc), 32'(expw));
                    end
                end else if (ms >= 17) begin
                    racc = {racc[13:0], audio_sdin};
                end else if (mf >= 1) begin
                    expw = (mf >= 2) ? lat_r[mf-2] : 16'h0000;
                    chk("right_word", 32'({racc, audio_sdin}), 32'(expw));
                end
            end
        end
    end

    task automatic set_in(input logic v, input logic [15:0] l, input logic [15:0] r);
        sample_valid = v;
        audio_left   = l;
        audio_right  = r;
    endtask

    task automatic next_frame();
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while ((t % 1024) != 0 && k < 1100);
        chk("frame_wait", 32'(k <= 1024), 32'd1);
    endtask

    task automatic clear_model();
        lat_l.delete();
        lat_r.delete();
        und  = 0;
        lacc = '0;
        racc = '0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mclk", 32'(audio_mclk), 0);
        chk("rst_sdin", 32'(audio_sdin), 0);
        chk("rst_ack", 32'(sample_ack), 0);
        chk("rst_und", 32'(underrun_cnt), 0);
        rst = 1'b1;

        // idle source: silence and one underrun per frame
        set_in(1'b0, 16'h0, 16'h0);
        next_frame();
        chk("und_first", 32'(underrun_cnt), 1);
        next_frame();
        chk("und_two", 32'(underrun_cnt), 2);

        // fixed pattern held for 10 frames
        set_in(1'b1, 16'hA5C3, 16'h3C5A);
        ack_seen = 0;
        repeat (10) next_frame();
        chk("ack_count", 32'(ack_seen), 10);
        chk("und_hold", 32'(underrun_cnt), 2);

        // three invalid frames then valid again
        set_in(1'b0, 16'h1111, 16'h2222);
        repeat (3) next_frame();
        chk("und_plus3", 32'(underrun_cnt), 5);
        set_in(1'b1, 16'h8001, 16'h7FFE);
        next_frame();

        // random traffic with occasional gaps
        repeat (12) begin
            set_in(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
            next_frame();
        end

        // square wave source
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, ((i / 5) % 2) ? 16'h5FFF : 16'h7000,
                         ((i / 5) % 2) ? 16'h7000 : 16'h5FFF);
            next_frame();
        end

        // asynchronous reset in the middle of a frame
        set_in(1'b1, 16'h7000, 16'h1235);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while ((t % 1024) != 700 && k < 1100);
        chk("mid_wait", 32'(k <= 1024), 1);
        chk("pre_lrck", 32'(audio_lrck), 1);
        rst = 1'b0;
        #1;
        chk("async_mclk", 32'(audio_mclk), 0);
        chk("async_sck", 32'(audio_sck), 0);
        chk("async_lrck", 32'(audio_lrck), 0);
        chk("async_sdin", 32'(audio_sdin), 0);
        chk("async_ack", 32'(sample_ack), 0);
        chk("async_und", 32'(underrun_cnt), 0);
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) next_frame();
        repeat (20) @(posedge clk);

        // saturation on the short-frame instance (64 clk per frame)
        @(posedge clk); #1;
        rst_s = 1'b1;
        repeat (254 * 64) @(posedge clk);
        @(negedge clk);
        chk("sat_254", 32'(s_und), 254);
        repeat (64) @(posedge clk);
        @(negedge clk);
        chk("sat_255", 32'(s_und), 255);
        repeat (45 * 64) @(posedge clk);
        @(negedge clk);
        chk("sat_300", 32'(s_und), 255);
        chk("sat_ack", 32'(s_ack), 0);
        chk("sat_sdin", 32'(s_sdin), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Consumer end of the audio sample interface. It takes 16-bit left/right PCM samples from the tone generators and serialises them to the Pmod I2S DAC.
- Generates MCLK, LRCK and SCK from the system clock, latches one stereo sample per frame through a valid/ack handshake, and shifts SDIN out in standard I2S format (MSB first, one-SCK delay after each LRCK edge).
- Sits between the note generators / mixer and the board speaker pins.

Parameters:
- DW, 16: sample width in bits.
- MCLK_SHIFT, 1: mclk = cnt[MCLK_SHIFT], giving clk/4.
- SCK_SHIFT, 4: sck = cnt[SCK_SHIFT], giving clk/32.
- LRCK_SHIFT, 9: lrck = cnt[LRCK_SHIFT], giving clk/1024. Legal only if H = 2^(LRCK_SHIFT-SCK_SHIFT-1) >= DW.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- audio_left  in  DW  left sample, two's complement.
- audio_right  in  DW  right sample, two's complement.
- sample_valid  in  1  source holds a valid stereo pair.
- sample_ack  out  1  one-clk pulse: pair latched this cycle.
- underrun_cnt  out  8  saturating count of frames latched without valid.
- audio_mclk  out  1  DAC master clock.
- audio_lrck  out  1  word select: 0 = left, 1 = right.
- audio_sck  out  1  serial bit clock.
- audio_sdin  out  1  serial data.

Behaviour:
- Reset (rst=0, asynchronous):
  - cnt=0; all outputs 0; hold_l, hold_r, r_lsb_prev and underrun_cnt = 0.
  - Reset asserted mid-frame aborts the frame immediately.
  - After release, the first frame starts at cnt=0 and transmits zeros until the first latch.
- Counter:
  - Free-running, width LRCK_SHIFT+1, increments every clk, wraps from all-ones to 0.
  - One frame = 2^(LRCK_SHIFT+1) clk (1024 at defaults).
- Clocks:
  - mclk, sck and lrck are direct registered counter bits, so all are glitch-free.
  - lrck falls at frame start (cnt wraps to 0) and rises at cnt = 2^LRCK_SHIFT.
- Latch point (cnt == all-ones, last clk of the frame):
  - If sample_valid=1: hold_l <= audio_left, hold_r <= audio_right; sample_ack=1 for exactly that cycle.
  - If sample_valid=0: hold_l <= 0, hold_r <= 0 (silence); sample_ack stays 0; underrun_cnt increments, saturating at 255.
  - In both cases r_lsb_prev <= old hold_r[0].
  - The source may change data the cycle after sample_ack.
- Slots:
  - slot s = cnt[LRCK_SHIFT:SCK_SHIFT+1], range 0..2H-1.
  - Slot boundaries coincide with sck falling edges.
- SDIN mapping (registered, updated on the clk edge that enters each slot, i.e. with sck falling; stable through the sck rising edge):
  - s=0: r_lsb_prev if H==DW, else 0.
  - 1<=s<=DW: hold_l[DW-s].
  - H+1<=s<=H+DW, with s<2H: hold_r[H+DW-s].
  - All other slots: 0.
  - At defaults (H=16): left MSB in slot 1, left LSB in slot 16, right MSB in slot 17, right LSB carried into slot 0 of the next frame.
- Latency: a sample latched at cnt=1023 has its MSB on sdin 32 clk later (slot 1 start) and is fully shifted by the next frame's slot 0.
- No back-pressure: ack rate is fixed at exactly one per frame when valid is held high.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_DW = 16.
  - MCLK_SHIFT, SCK_SHIFT, LRCK_SHIFT constants.
  - Derived FRAME_CLKS = 1024 and SLOTS_PER_CH = 16.
  - Silence value 16'h0000.
- Natural sub-module i2s_clk_gen:
  - Owns the counter and produces mclk, sck, lrck, slot index, slot_start strobe and frame_end strobe.
  - audio_i2s_tx keeps the handshake, hold registers, underrun counter and sdin mux.

Test Plan:
- Release reset at t0, sample_valid=0 -> mclk period 4 clk; sck period 32; lrck period 1024, first rise 512 clk after release; sdin=0 throughout; underrun_cnt=1 after the first frame end.
- sample_valid=1, L=16'hA5C3, R=16'h3C5A held constant -> sampling sdin at sck rising edges gives A5C3 in slots 1-16, bits 15..1 of 3C5A in slots 17-31, and 0 (3C5A LSB) in slot 0 of the next frame.
- sample_valid held 1 for 10 frames -> exactly 10 sample_ack pulses, each at cnt=1023, spaced 1024 clk apart; underrun_cnt unchanged.
- sample_valid=0 for 3 frames, then 1 -> underrun_cnt += 3; data slots all 0 in those frames; first valid frame transmits correctly. Separately, 300 invalid frames -> underrun_cnt = 255, no wrap.
- Drive rst=0 at cnt=700 with L=16'h7000 -> all outputs 0 within the same cycle (asynchronous); after release, counting restarts at 0 and the next frame transmits zeros until the next latch.
- Feed a square-wave source alternating 16'h7000 / 16'h5FFF every 5 frames -> decoded serial samples match the source stream, delayed by exactly one frame.
